// File: rtl/unidade_controle_jogo.sv
// unidade_controle_jogo: Moore FSM sequencing a memory-game round (play, compare, advance, win/lose).
// Optional per-play timer and fim_timeout state enabled by defining TIMEOUT_EN.
module unidade_controle_jogo #(
    parameter int TIMEOUT_CYCLES = 3000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       jogar,
    input  logic       tem_jogada,
    input  logic       jogada_igual_memoria,
    input  logic       endereco_igual_sequencia,
    input  logic       fim_sequencia,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraS,
    output logic       contaS,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       ganhou,
    output logic       perdeu,
    output logic       timeout,
    output logic [3:0] db_estado
);
    typedef enum logic [3:0] {
        INICIAL           = 4'h0,
        PREPARACAO        = 4'h1,
        INICIA_SEQUENCIA  = 4'h2,
        ESPERA_JOGADA     = 4'h3,
        REGISTRA          = 4'h4,
        COMPARACAO        = 4'h5,
        PROXIMO           = 4'h6,
        PROXIMA_SEQUENCIA = 4'h7,
        FIM_ACERTOU       = 4'hA,
        FIM_TIMEOUT       = 4'hD,
        FIM_ERROU         = 4'hE
    } estado_t;

    estado_t estado_q, estado_d;
    logic    expirou;

    if (TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("TIMEOUT_CYCLES must be at least 2");
    end

`ifdef TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] timer_q, timer_d;
    // Timer only runs while waiting for a play, so every re-entry starts from zero.
    always_comb timer_d = (estado_q == ESPERA_JOGADA) ? timer_q + 1'b1 : '0;
    always_ff @(posedge clock) begin
        if (reset) timer_q <= '0;
        else       timer_q <= timer_d;
    end
    assign expirou = (estado_q == ESPERA_JOGADA) && (timer_q == TW'(TIMEOUT_CYCLES - 1));
    assign timeout = (estado_q == FIM_TIMEOUT);
`else
    assign expirou = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) estado_q <= INICIAL;
        else       estado_q <= estado_d;
    end

    always_comb begin
        estado_d = INICIAL;
        case (estado_q)
            INICIAL:           estado_d = jogar ? PREPARACAO : INICIAL;
            PREPARACAO:        estado_d = INICIA_SEQUENCIA;
            INICIA_SEQUENCIA:  estado_d = ESPERA_JOGADA;
            ESPERA_JOGADA:     estado_d = tem_jogada ? REGISTRA : (expirou ? FIM_TIMEOUT : ESPERA_JOGADA);
            REGISTRA:          estado_d = COMPARACAO;
            COMPARACAO:        estado_d = !jogada_igual_memoria     ? FIM_ERROU :
                                          !endereco_igual_sequencia ? PROXIMO :
                                          !fim_sequencia            ? PROXIMA_SEQUENCIA : FIM_ACERTOU;
            PROXIMO:           estado_d = ESPERA_JOGADA;
            PROXIMA_SEQUENCIA: estado_d = INICIA_SEQUENCIA;
            FIM_ACERTOU:       estado_d = jogar ? PREPARACAO : FIM_ACERTOU;
            FIM_TIMEOUT:       estado_d = jogar ? PREPARACAO : FIM_TIMEOUT;
            FIM_ERROU:         estado_d = jogar ? PREPARACAO : FIM_ERROU;
            default:           estado_d = INICIAL;
        endcase
    end

    assign zeraE     = (estado_q == PREPARACAO) || (estado_q == INICIA_SEQUENCIA);
    assign contaE    = (estado_q == PROXIMO);
    assign zeraS     = (estado_q == PREPARACAO);
    assign contaS    = (estado_q == PROXIMA_SEQUENCIA);
    assign zeraR     = (estado_q == PREPARACAO);
    assign registraR = (estado_q == REGISTRA);
    assign ganhou    = (estado_q == FIM_ACERTOU);
    assign perdeu    = (estado_q == FIM_ERROU);
    assign pronto    = (estado_q == FIM_ACERTOU) || (estado_q == FIM_ERROU) || (estado_q == FIM_TIMEOUT);
    assign db_estado = estado_q;
endmodule

// File: tb/tb_unidade_controle_jogo.sv
// tb_unidade_controle_jogo: table-driven directed vectors plus timer corner sequences.
module tb_unidade_controle_jogo;
    logic clock = 0, reset = 0, jogar = 0, tem_jogada = 0;
    logic jogada_igual_memoria = 0, endereco_igual_sequencia = 0, fim_sequencia = 0;
    logic zeraE, contaE, zeraS, contaS, zeraR, registraR, pronto, ganhou, perdeu, timeout;
    logic [3:0] db_estado;
    int checks = 0, errors = 0;

    unidade_controle_jogo dut (
        .clock(clock), .reset(reset), .jogar(jogar), .tem_jogada(tem_jogada),
        .jogada_igual_memoria(jogada_igual_memoria),
        .endereco_igual_sequencia(endereco_igual_sequencia),
        .fim_sequencia(fim_sequencia),
        .zeraE(zeraE), .contaE(contaE), .zeraS(zeraS), .contaS(contaS),
        .zeraR(zeraR), .registraR(registraR), .pronto(pronto), .ganhou(ganhou),
        .perdeu(perdeu), .timeout(timeout), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [5:0] in;
        logic [3:0] st;
        logic [9:0] o;
    } vec_t;
    vec_t vecs[$];

    // {zeraE,contaE,zeraS,contaS,zeraR,registraR,pronto,ganhou,perdeu,timeout}
    function automatic logic [9:0] outs_for(input logic [3:0] st);
        case (st)
            4'h1:    return 10'b1010100000;
            4'h2:    return 10'b1000000000;
            4'h4:    return 10'b0000010000;
            4'h6:    return 10'b0100000000;
            4'h7:    return 10'b0001000000;
            4'hA:    return 10'b0000001100;
            4'hD:    return 10'b0000001001;
            4'hE:    return 10'b0000001010;
            default: return 10'b0000000000;
        endcase
    endfunction

    // in = {reset, jogar, tem_jogada, igual, end_igual, fim_seq}
    task automatic add(input logic [5:0] in, input logic [3:0] st);
        vec_t v;
        v.in = in;
        v.st = st;
        v.o  = outs_for(st);
        vecs.push_back(v);
    endtask

    function automatic logic [9:0] dut_o();
        return {zeraE, contaE, zeraS, contaS, zeraR, registraR, pronto, ganhou, perdeu, timeout};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] in);
        {reset, jogar, tem_jogada, jogada_igual_memoria, endereco_igual_sequencia, fim_sequencia} = in;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic start_game();
        drive(6'b010000); step();
        drive(6'b000000); step(); step();
    endtask

    initial begin
        add(6'b100000, 4'h0);
        add(6'b010000, 4'h1); add(6'b010000, 4'h2); add(6'b010000, 4'h3);
        add(6'b010000, 4'h3); add(6'b010000, 4'h3);
        // level 1
        add(6'b001000, 4'h4); add(6'b000110, 4'h5); add(6'b000110, 4'h7);
        add(6'b000000, 4'h2); add(6'b000000, 4'h3);
        // level 2
        add(6'b001000, 4'h4); add(6'b000000, 4'h5); add(6'b000100, 4'h6); add(6'b000000, 4'h3);
        add(6'b001000, 4'h4); add(6'b000000, 4'h5); add(6'b000110, 4'h7);
        add(6'b001000, 4'h2); add(6'b000000, 4'h3);
        // level 3
        add(6'b001000, 4'h4); add(6'b000000, 4'h5); add(6'b000100, 4'h6); add(6'b000000, 4'h3);
        add(6'b001000, 4'h4); add(6'b000000, 4'h5); add(6'b000100, 4'h6); add(6'b000000, 4'h3);
        add(6'b001000, 4'h4); add(6'b000000, 4'h5); add(6'b000110, 4'h7);
        add(6'b000000, 4'h2); add(6'b000000, 4'h3);
        // level 4, last level: fim_sequencia without address match still advances
        for (int i = 0; i < 3; i++) begin
            add(6'b001000, 4'h4); add(6'b000000, 4'h5); add(6'b000101, 4'h6); add(6'b000000, 4'h3);
        end
        add(6'b001000, 4'h4); add(6'b000000, 4'h5); add(6'b000111, 4'hA);
        add(6'b001000, 4'hA); add(6'b000000, 4'hA);
        // second game: wrong play on level 2
        add(6'b010000, 4'h1); add(6'b000000, 4'h2); add(6'b000000, 4'h3);
        add(6'b001000, 4'h4); add(6'b000000, 4'h5); add(6'b000110, 4'h7);
        add(6'b000000, 4'h2); add(6'b000000, 4'h3);
        add(6'b001000, 4'h4); add(6'b000000, 4'h5); add(6'b000000, 4'hE);
        add(6'b001100, 4'hE);
        add(6'b010000, 4'h1); add(6'b000000, 4'h2); add(6'b000000, 4'h3);
        add(6'b001000, 4'h4); add(6'b000000, 4'h5);
        add(6'b100111, 4'h0); add(6'b000000, 4'h0);
        // reset from terminal win, with jogar asserted the same cycle
        add(6'b010000, 4'h1); add(6'b000000, 4'h2); add(6'b000000, 4'h3);
        add(6'b001000, 4'h4); add(6'b000000, 4'h5); add(6'b000111, 4'hA);
        add(6'b110000, 4'h0);
        // reset beats tem_jogada in espera_jogada
        add(6'b010000, 4'h1); add(6'b000000, 4'h2); add(6'b000000, 4'h3);
        add(6'b101000, 4'h0);

        foreach (vecs[i]) begin
            drive(vecs[i].in);
            step();
            check($sformatf("v%0d_state", i), 16'(db_estado), 16'(vecs[i].st));
            check($sformatf("v%0d_outs", i), 16'(dut_o()), 16'(vecs[i].o));
        end

`ifdef TIMEOUT_EN
        start_game();
        check("to_entry", 16'(db_estado), 16'h3);
        for (int i = 0; i < 2999; i++) step();
        check("to_before", 16'(db_estado), 16'h3);
        step();
        check("to_state", 16'(db_estado), 16'hD);
        check("to_outs", 16'(dut_o()), 16'(outs_for(4'hD)));
        start_game();
        for (int i = 0; i < 2999; i++) step();
        drive(6'b001000); step();
        check("to_press_last", 16'(db_estado), 16'h4);
        drive(6'b000000); step();
        drive(6'b000100); step(); step();
        for (int i = 0; i < 2999; i++) step();
        check("to_restart", 16'(db_estado), 16'h3);
        step();
        check("to_restart_exp", 16'(db_estado), 16'hD);
`else
        begin
            int bad = 0;
            start_game();
            for (int i = 0; i < 10000; i++) begin
                step();
                if (db_estado !== 4'h3 || timeout !== 1'b0) bad++;
            end
            check("idle_10000_bad_cycles", 16'(bad), 16'h0);
            check("idle_state", 16'(db_estado), 16'h3);
            check("idle_timeout", 16'(timeout), 16'h0);
        end
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/unidade_controle_jogo.md
UNIDADE_CONTROLE_JOGO -- requirements
Module: unidade_controle_jogo

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 3000, clock cycles allowed per play in espera_jogada (3 s at 1 kHz).
REQ-002 Ports (name direction width meaning):
- clock  in  1  single system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- jogar  in  1  start/restart request.
- tem_jogada  in  1  one-cycle pulse from datapath: button press detected.
- jogada_igual_memoria  in  1  registered play equals memory at current address.
- endereco_igual_sequencia  in  1  address counter equals current sequence length.
- fim_sequencia  in  1  sequence counter at last level.
- zeraE, contaE  out  1  clear / increment address counter.
- zeraS, contaS  out  1  clear / increment sequence counter.
- zeraR, registraR  out  1  clear / load play register.
- pronto, ganhou, perdeu, timeout  out  1  game status.
- db_estado  out  4  current state code.

Function
REQ-003 Moore FSM; all outputs SHALL decode from current state only; state codes: inicial 0x0, preparacao 0x1, inicia_sequencia 0x2, espera_jogada 0x3, registra 0x4, comparacao 0x5, proximo 0x6, proxima_sequencia 0x7, fim_acertou 0xA, fim_timeout 0xD, fim_errou 0xE.
REQ-004 inicial: jogar=1 -> preparacao; else stay.
REQ-005 preparacao asserts zeraE, zeraS, zeraR; next inicia_sequencia unconditionally.
REQ-006 inicia_sequencia asserts zeraE; next espera_jogada.
REQ-007 espera_jogada: tem_jogada=1 -> registra; else timer expiry -> fim_timeout; else stay; tem_jogada wins when simultaneous with expiry.
REQ-008 registra asserts registraR; next comparacao.
REQ-009 comparacao: !jogada_igual_memoria -> fim_errou; match & !endereco_igual_sequencia -> proximo; match & endereco_igual_sequencia & !fim_sequencia -> proxima_sequencia; match & endereco_igual_sequencia & fim_sequencia -> fim_acertou.
REQ-010 proximo asserts contaE -> espera_jogada; proxima_sequencia asserts contaS -> inicia_sequencia.
REQ-011 Terminal states assert pronto plus ganhou (0xA), perdeu (0xE) or timeout (0xD); held until jogar=1 -> preparacao.
REQ-012 Timer: counter width ceil(log2(TIMEOUT_CYCLES))+1; cleared in every state except espera_jogada; increments each cycle in espera_jogada; expiry when count = TIMEOUT_CYCLES-1, i.e. fim_timeout entered exactly TIMEOUT_CYCLES cycles after entering espera_jogada.
REQ-013 Timer restarts from 0 on each re-entry to espera_jogada (after proximo or inicia_sequencia).
REQ-014 jogar ignored in all non-inicial, non-terminal states; tem_jogada ignored outside espera_jogada.
REQ-015 Unused state codes SHALL go to inicial on the next edge.

Reset
REQ-016 reset=1 at a rising edge SHALL force inicial and clear timer regardless of state, including mid-game and terminal states.
REQ-017 In inicial all outputs are 0 and db_estado=0x0.
REQ-018 reset has priority over jogar and tem_jogada in the same cycle.

Configuration
REQ-019 Macro TIMEOUT_EN: defined -> timer and fim_timeout per REQ-007/012/013.
REQ-020 Without TIMEOUT_EN: no timer logic, espera_jogada waits indefinitely for tem_jogada, timeout output tied to 0, state 0xD unreachable.

Verification
REQ-021 reset 1 cycle, jogar 5 cycles -> states 0x0,0x1,0x2,0x3; zeraE/zeraS/zeraR high one cycle in 0x1.
REQ-022 Full game, 4 levels, all correct plays -> each level ends in 0x7 (contaS 1 cycle); after final play 0xA, ganhou=1, pronto=1 held.
REQ-023 Wrong play (jogada_igual_memoria=0) on level 2 -> 0x4,0x5,0xE; perdeu=1, pronto=1; jogar -> 0x1.
REQ-024 TIMEOUT_EN, TIMEOUT_CYCLES=3000, no press -> 0xD exactly 3000 cycles after 0x3 entry, timeout=1; press at cycle 2999 -> 0x4 instead.
REQ-025 Without TIMEOUT_EN, idle 10000 cycles in 0x3 -> stays 0x3, timeout=0.
REQ-026 reset asserted in 0x5 and in 0xA -> 0x0 next edge, all outputs 0.
